// File: rtl/mips32_prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_prog_loader_if
//  Description : Host byte stream plus memory write port of the pipe_MIPS32
//                program loader. The master modport is the loader itself
//                (it masters the memory write bus and answers the stream);
//                the slave modport is the host link / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips32_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mips32_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_prog_loader
//  Description : Writer side of the pipe_MIPS32 instruction/data memory.
//                Takes a big-endian frame LEN[15:8], LEN[7:0], 4*LEN payload
//                bytes (MSB first per word) and an optional XOR check byte,
//                writes each assembled word to memory one cycle after its
//                4th byte, and releases the CPU (cpu_run) once the image is
//                complete.
//                Build option LOADER_CHKSUM_EN: when defined a trailing CHK
//                byte (XOR of all prior frame bytes) is required and checked;
//                when undefined the frame ends after the last payload word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips32_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  wire logic                   clk1,
    input  wire logic                   rst,
    mips32_prog_loader_if.master        bus,
    output logic [15:0]                 words_done,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        cpu_run
);

    // FSM encoding
    localparam logic [2:0] c_st_hdr0 = 3'd0;
    localparam logic [2:0] c_st_hdr1 = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_chk  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;
    localparam logic [2:0] c_st_err  = 3'd5;
    // One-cycle settle after the final write so the CPU is only released
    // once the last word has landed in memory (no-checksum build only).
    localparam logic [2:0] c_st_fin  = 3'd6;

    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       c_max_words = 17'(MAX_WORDS);

    logic [2:0]        r_state;
    logic [7:0]        r_hdr_hi;
    logic [15:0]       r_len;
    logic [23:0]       r_asm;
    logic [1:0]        r_byte_cnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_ready;
    logic              w_acc;
    logic [15:0]       w_len;
    logic              w_len_big;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_word_addr;

    // Byte-acceptance handshake and header/word decode helpers
    always_comb begin
        w_ready     = 1'b0;
        if (!rst) begin
            w_ready = (r_state == c_st_hdr0) || (r_state == c_st_hdr1) ||
                      (r_state == c_st_data) || (r_state == c_st_chk);
        end
        w_acc       = bus.s_valid && w_ready;
        w_len       = {r_hdr_hi, bus.s_data};
        w_len_big   = {1'b0, w_len} > c_max_words;
        // words_done doubles as the index of the word being assembled
        w_last_word = (words_done + 16'd1) == r_len;
        w_word_addr = c_base + ADDR_W'(words_done);
    end

    assign bus.s_ready   = w_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

`ifdef LOADER_CHKSUM_EN
    logic [7:0] r_xor;

    // Running XOR over every frame byte ahead of the check byte
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_xor <= 8'h00;
        end else if (w_acc && (r_state != c_st_chk)) begin
            r_xor <= r_xor ^ bus.s_data;
        end
    end
`endif

    // Frame FSM, word assembly and the registered memory write port
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_hdr0;
            r_hdr_hi    <= 8'h00;
            r_len       <= 16'h0000;
            r_asm       <= 24'h000000;
            r_byte_cnt  <= 2'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0000_0000;
            words_done  <= 16'h0000;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_st_hdr0: begin
                    if (w_acc) begin
                        r_hdr_hi <= bus.s_data;
                        r_state  <= c_st_hdr1;
                    end
                end
                c_st_hdr1: begin
                    if (w_acc) begin
                        r_len <= w_len;
                        if (w_len_big) begin
                            r_state <= c_st_err;
                        end else if (w_len == 16'h0000) begin
`ifdef LOADER_CHKSUM_EN
                            r_state <= c_st_chk;
`else
                            r_state <= c_st_done;
`endif
                        end else begin
                            r_state <= c_st_data;
                        end
                    end
                end
                c_st_data: begin
                    if (w_acc) begin
                        r_asm      <= {r_asm[15:0], bus.s_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= {r_asm, bus.s_data};
                            r_mem_addr  <= w_word_addr;
                            words_done  <= words_done + 16'd1;
                            if (w_last_word) begin
`ifdef LOADER_CHKSUM_EN
                                r_state <= c_st_chk;
`else
                                r_state <= c_st_fin;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHKSUM_EN
                c_st_chk: begin
                    if (w_acc) begin
                        r_state <= (bus.s_data == r_xor) ? c_st_done : c_st_err;
                    end
                end
`endif
                c_st_fin: begin
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    r_state <= c_st_done;
                end
                c_st_err: begin
                    r_state <= c_st_err;
                end
                default: begin
                    r_state <= c_st_err;
                end
            endcase
        end
    end

    // Status decode; cpu_run follows the async-reset state register directly
    always_comb begin
        busy    = (r_state == c_st_hdr0) || (r_state == c_st_hdr1) ||
                  (r_state == c_st_data) || (r_state == c_st_chk)  ||
                  (r_state == c_st_fin);
        done    = (r_state == c_st_done);
        err     = (r_state == c_st_err);
        cpu_run = (r_state == c_st_done);
    end

endmodule
`default_nettype wire

// File: tb/tb_mips32_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips32_prog_loader
//  Description : Self-checking bench for mips32_prog_loader. Two instances
//                share one byte stream: BASE_ADDR=0 and BASE_ADDR=1022 (the
//                latter exercises address wrap). Expected writes are queued
//                when the completing byte is driven and popped when mem_we
//                is seen one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_prog_loader;

`ifdef LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int MAXW = 1024;

    logic       clk1 = 1'b0;
    logic       rst  = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;

    always #5 clk1 = ~clk1;

    mips32_prog_loader_if #(.ADDR_W(10)) bus0 ();
    mips32_prog_loader_if #(.ADDR_W(10)) bus1 ();

    assign bus0.s_valid = s_valid;
    assign bus0.s_data  = s_data;
    assign bus1.s_valid = s_valid;
    assign bus1.s_data  = s_data;

    logic [15:0] wd0, wd1;
    logic        busy0, done0, err0, run0;
    logic        busy1, done1, err1, run1;

    mips32_prog_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(MAXW)) dut0 (
        .clk1(clk1), .rst(rst), .bus(bus0), .words_done(wd0),
        .busy(busy0), .done(done0), .err(err0), .cpu_run(run0)
    );

    mips32_prog_loader #(.ADDR_W(10), .BASE_ADDR(1022), .MAX_WORDS(MAXW)) dut1 (
        .clk1(clk1), .rst(rst), .bus(bus1), .words_done(wd1),
        .busy(busy1), .done(done1), .err(err1), .cpu_run(run1)
    );

    // Memory word 0 as the CPU memory would hold it
    logic [31:0] mem_w0 = 32'h0000_0000;
    always @(posedge clk1) begin
        if (bus0.mem_we && (bus0.mem_addr == 10'd0)) mem_w0 <= bus0.mem_wdata;
    end

    typedef struct {
        string        name;
        logic [159:0] data;   // bytes right-aligned, first byte most significant
        int           n;
        int           gap;    // idle cycles after each byte
        logic         e_done;
        logic         e_err;
        int           e_words;
    } vec_t;

    typedef struct {
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [31:0] w;
    } wr_t;

    vec_t vecs[7];
    wr_t  q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the frame parser
    int          m_ph;     // 0 hdr0, 1 hdr1, 2 data, 3 chk, 4 done, 5 err
    logic [7:0]  m_hi;
    int          m_len;
    int          m_cnt;
    int          m_idx;
    logic [31:0] m_word;
    logic [7:0]  m_xor;
    logic        exp_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_hi = 8'h00; m_len = 0; m_cnt = 0; m_idx = 0;
        m_word = 32'h0; m_xor = 8'h00; exp_we = 1'b0;
        q.delete();
    endtask

    task automatic model_byte(input logic [7:0] d);
        wr_t e;
        case (m_ph)
            0: begin m_hi = d; m_xor ^= d; m_ph = 1; end
            1: begin
                m_len = int'({m_hi, d});
                m_xor ^= d;
                if (m_len > MAXW)   m_ph = 5;
                else if (m_len == 0) m_ph = CHK_EN ? 3 : 4;
                else                 m_ph = 2;
            end
            2: begin
                m_xor ^= d;
                m_word = {m_word[23:0], d};
                m_cnt++;
                if (m_cnt == 4) begin
                    e.a0 = 10'(m_idx);
                    e.a1 = 10'((1022 + m_idx) % 1024);
                    e.w  = m_word;
                    q.push_back(e);
                    exp_we = 1'b1;
                    m_idx++;
                    m_cnt = 0;
                    if (m_idx == m_len) m_ph = CHK_EN ? 3 : 4;
                end
            end
            3: m_ph = (d == m_xor) ? 4 : 5;
            default: ;
        endcase
    endtask

    // One cycle: check what the previous edge produced, then present the next input
    task automatic step(input logic v, input logic [7:0] d);
        wr_t  e;
        logic rdy;
        @(negedge clk1);
        check("mem_we0", {31'b0, bus0.mem_we}, {31'b0, exp_we});
        check("mem_we1", {31'b0, bus1.mem_we}, {31'b0, exp_we});
        if (bus0.mem_we && exp_we) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                check("addr0",  32'(bus0.mem_addr), 32'(e.a0));
                check("addr1",  32'(bus1.mem_addr), 32'(e.a1));
                check("wdata0", bus0.mem_wdata, e.w);
                check("wdata1", bus1.mem_wdata, e.w);
            end else begin
                check("wr_queue_underflow", 32'(q.size()), 32'd1);
            end
        end
        rdy = (m_ph <= 3);
        check("s_ready0", {31'b0, bus0.s_ready}, {31'b0, rdy});
        check("s_ready1", {31'b0, bus1.s_ready}, {31'b0, rdy});
        s_valid = v;
        s_data  = d;
        exp_we  = 1'b0;
        if (v && rdy) model_byte(d);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst = 1'b1;
        s_valid = 1'b0;
        #1;
        check("rst_s_ready", {31'b0, bus0.s_ready}, 32'd0);
        check("rst_mem_we",  {31'b0, bus0.mem_we},  32'd0);
        check("rst_addr",    32'(bus0.mem_addr),    32'd0);
        check("rst_wdata",   bus0.mem_wdata,        32'd0);
        check("rst_words",   32'(wd0),              32'd0);
        check("rst_done",    {31'b0, done0},        32'd0);
        check("rst_err",     {31'b0, err0},         32'd0);
        check("rst_cpu_run", {31'b0, run0 | run1},  32'd0);
        @(negedge clk1);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        for (int i = 0; i < v.n; i++) begin
            step(1'b1, v.data[8*(v.n-1-i) +: 8]);
            for (int g = 0; g < v.gap; g++) step(1'b0, 8'h00);
        end
        repeat (3) step(1'b0, 8'h00);
        check({v.name, ":done"},    {31'b0, done0}, {31'b0, v.e_done});
        check({v.name, ":err"},     {31'b0, err0},  {31'b0, v.e_err});
        check({v.name, ":cpu_run"}, {31'b0, run0},  {31'b0, v.e_done});
        check({v.name, ":busy"},    {31'b0, busy0}, 32'd0);
        check({v.name, ":words"},   32'(wd0),       32'(v.e_words));
        check({v.name, ":done1"},   {31'b0, done1}, {31'b0, v.e_done});
        check({v.name, ":err1"},    {31'b0, err1},  {31'b0, v.e_err});
        check({v.name, ":words1"},  32'(wd1),       32'(v.e_words));
        check({v.name, ":pending"}, 32'(q.size()),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef LOADER_CHKSUM_EN
        vecs[0] = '{"good",     160'h0003280a00c828020001fc0000003e, 15, 0, 1'b1, 1'b0, 3};
        vecs[1] = '{"bad_chk",  160'h0003280a00c828020001fc0000003f, 15, 0, 1'b0, 1'b1, 3};
        vecs[2] = '{"len0",     160'h000000,                          3, 0, 1'b1, 1'b0, 0};
        vecs[3] = '{"len1025",  160'h0401aabbccdd,                    6, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{"one_word", 160'h0001deadbeef23,                  7, 0, 1'b1, 1'b0, 1};
        vecs[5] = '{"toggle",   160'h0003280a00c828020001fc0000003e, 15, 1, 1'b1, 1'b0, 3};
        vecs[6] = '{"hold",     160'h0003280a00c828020001fc0000003e, 15, 3, 1'b1, 1'b0, 3};
`else
        vecs[0] = '{"good",     160'h0003280a00c828020001fc000000,   14, 0, 1'b1, 1'b0, 3};
        vecs[1] = '{"trailing", 160'h0003280a00c828020001fc0000003f, 15, 0, 1'b1, 1'b0, 3};
        vecs[2] = '{"len0",     160'h000000,                          3, 0, 1'b1, 1'b0, 0};
        vecs[3] = '{"len1025",  160'h0401aabbccdd,                    6, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{"one_word", 160'h0001deadbeef,                    6, 0, 1'b1, 1'b0, 1};
        vecs[5] = '{"toggle",   160'h0003280a00c828020001fc000000,   14, 1, 1'b1, 1'b0, 3};
        vecs[6] = '{"hold",     160'h0003280a00c828020001fc000000,   14, 3, 1'b1, 1'b0, 3};
`endif
        model_reset();

        // Reset after six payload bytes: word 0 already written, rest aborted
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, vecs[0].data[8*(vecs[0].n-1-i) +: 8]);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_s_ready", {31'b0, bus0.s_ready}, 32'd0);
        check("mid_rst_words",   32'(wd0),              32'd0);
        check("mid_rst_busy_we", {31'b0, bus0.mem_we},  32'd0);
        check("mid_rst_word0",   mem_w0,                32'h280a00c8);
        @(negedge clk1);
        rst = 1'b0;
        s_valid = 1'b0;
        model_reset();

        // A fresh full frame after the abort
        run_vec(vecs[0]);

        // cpu_run must drop as soon as rst rises, without waiting for a clock
        @(negedge clk1);
        #2 rst = 1'b1;
        #1;
        check("async_cpu_run", {31'b0, run0}, 32'd0);
        check("async_done",    {31'b0, done0}, 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        model_reset();

        // Reset during the write cycle cancels the pending strobe
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, vecs[0].data[8*(vecs[0].n-1-i) +: 8]);
        @(posedge clk1);
        #1;
        check("we_before_rst", {31'b0, bus0.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("we_cancelled",  {31'b0, bus0.mem_we}, 32'd0);
        check("we_cancel_words", 32'(wd0), 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        s_valid = 1'b0;
        model_reset();

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
